mux_n_rr: RTL and testbench
===========================

// Module: mux_n_rr
// PURPOSE
//   Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on every input and on the output.
//   Selection is either fixed, driven by a select port, or round-robin over channels that have valid data.
//   Sits between N_CH producer channels and one consumer; it generalises the fixed 8:1 one-bit mux into a streaming block.
// PARAMETERS
//   N_CH    8   number of input channels (>=2)
//   DATA_W  8   data width per channel (>=1)
//   SEL_W   3   select/channel-index width; must equal clog2(N_CH), otherwise elaboration error
// PORTS
//   clk       in   1             clock, rising edge
//   rst_n     in   1             asynchronous reset, active low
//   in_data   in   N_CH*DATA_W   channel i occupies bits [i*DATA_W +: DATA_W]
//   in_valid  in   N_CH          per-channel data valid
//   in_ready  out  N_CH          per-channel accept; a beat transfers when in_valid[i] & in_ready[i]
//   mode      in   1             0 = fixed select via sel, 1 = round-robin
//   sel       in   SEL_W         channel index used in fixed mode
//   out_data  out  DATA_W        registered output data
//   out_ch    out  SEL_W         index of the channel that supplied out_data
//   out_valid out  1             output holds a beat
//   out_ready in   1             consumer accept; a beat transfers when out_valid & out_ready
// BEHAVIOUR
//   - Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, rr_ptr=0; in_ready=0 while rst_n=0.
//   - load_en = !out_valid | out_ready. The output register accepts one new beat per cycle, giving full throughput.
//   - Grant (combinational, same cycle):
//       fixed: gnt = sel when sel < N_CH and in_valid[sel]; otherwise no grant.
//       rr: gnt = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... with wrap modulo N_CH.
//   - in_ready[i] = load_en & grant_valid & (gnt == i). At most one bit is set. in_ready never depends on in_valid[j] for j != gnt.
//   - Latency is 1 cycle. A beat accepted in cycle t appears on out_data/out_ch with out_valid=1 in cycle t+1.
//   - Output stall: while out_valid & !out_ready, out_data and out_ch hold exactly and in_ready is all 0.
//   - If load_en and there is no grant: out_valid goes to 0 next cycle and out_data/out_ch hold their old values.
//   - rr_ptr updates only on an accepted transfer in rr mode: rr_ptr <= (gnt == N_CH-1) ? 0 : gnt+1.
//     rr_ptr is unchanged in fixed mode. This gives fair service: a continuously valid channel waits at most N_CH-1 grants.
//   - mode or sel changes take effect at the next grant evaluation; a held output beat is never altered.
//   - sel >= N_CH (non-power-of-two N_CH): no grant and no transfer; not an error.
//   - Reset asserted mid-stream: any held beat is discarded and the block restarts from reset values after rst_n rises.
// CONFIGURATION
//   MUX_N_RR_CNT_EN defined: adds output port xfer_cnt [N_CH*16], one 16-bit counter per channel.
//     - A channel's counter increments on each accepted input beat and saturates at 16'hFFFF.
//     - All counters reset to 0 on rst_n=0.
//   MUX_N_RR_CNT_EN undefined: xfer_cnt port and the counters do not exist; all other behaviour is identical.
// TESTING
//   1. Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0.
//   2. Fixed mode, sel=5, in_valid=8'hFF, ch5 data=8'hA5, out_ready=1
//      -> in_ready=8'h20; next cycle out_data=8'hA5, out_ch=5, out_valid=1.
//   3. Round-robin, in_valid=8'hFF held, out_ready=1 -> out_ch sequence 0,1,...,7,0; one beat per cycle; wrap after ch7.
//   4. Round-robin, in_valid=8'h81, rr_ptr=1 -> grant ch7 then ch0, repeating.
//   5. Stall: out_ready=0 for 3 cycles while out_valid=1 -> out_data/out_ch unchanged, in_ready=0;
//      releasing out_ready loads the next beat in the same cycle.
//   6. MUX_N_RR_CNT_EN: 70000 beats on ch2 -> xfer_cnt[2] saturates at 16'hFFFF; other channels stay 0.

Source files
------------

// File: rtl/mux_n_rr.sv
// N-channel registered multiplexer with valid/ready on every port; fixed or round-robin selection.
// Optional per-channel 16-bit saturating beat counters on xfer_cnt when MUX_N_RR_CNT_EN is defined.
module mux_n_rr #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef MUX_N_RR_CNT_EN
  ,
  output logic [N_CH*16-1:0]       xfer_cnt
`endif
);

  generate
    if (SEL_W != $clog2(N_CH) || N_CH < 2 || DATA_W < 1) begin : g_param_chk
      $error("mux_n_rr: SEL_W must equal clog2(N_CH), N_CH >= 2, DATA_W >= 1");
    end
  endgenerate

  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    gnt;
  logic                gnt_vld;
  logic                load_en;
  logic                xfer;
  logic [DATA_W-1:0]   gnt_data;
  logic [2*N_CH-1:0]   valid_dbl;
  logic [N_CH-1:0]     valid_rot;
  logic [SEL_W:0]      rr_sum;

  assign load_en   = !out_valid || out_ready;
  assign xfer      = load_en && gnt_vld;

  // valid_rot[k] is the valid of channel (rr_ptr + k) mod N_CH
  assign valid_dbl = {in_valid, in_valid} >> rr_ptr;
  assign valid_rot = valid_dbl[N_CH-1:0];

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    rr_sum  = '0;
    if (!mode) begin
      for (int i = 0; i < N_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt     = SEL_W'(i);
          gnt_vld = 1'b1;
        end
      end
    end else begin
      // Scan downwards so the nearest valid channel after rr_ptr wins last.
      for (int k = N_CH - 1; k >= 0; k--) begin
        if (valid_rot[k]) begin
          rr_sum = {1'b0, rr_ptr} + (SEL_W+1)'(k);
          if (rr_sum >= (SEL_W+1)'(N_CH)) rr_sum = rr_sum - (SEL_W+1)'(N_CH);
          gnt     = rr_sum[SEL_W-1:0];
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt == SEL_W'(i)) gnt_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rst_n && xfer && gnt == SEL_W'(i)) in_ready[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data <= gnt_data;
        out_ch   <= gnt;
        if (mode) rr_ptr <= (gnt == SEL_W'(N_CH - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

`ifdef MUX_N_RR_CNT_EN
  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_cnt
      logic [15:0] cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (xfer && gnt == SEL_W'(c) && cnt != 16'hFFFF) begin
          cnt <= cnt + 16'd1;
        end
      end
      assign xfer_cnt[c*16 +: 16] = cnt;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_mux_n_rr.sv
// Self-checking bench for mux_n_rr: directed literal checks plus a per-cycle behavioural model under random stimulus.
// Exercises the xfer_cnt saturation case when MUX_N_RR_CNT_EN is defined.
module tb_mux_n_rr;
  localparam int N = 8;
  localparam int W = 8;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '1;
  logic [N-1:0]   in_ready;
  logic           mode = 1'b0;
  logic [S-1:0]   sel = '0;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_ch;
  logic           out_valid;
  logic           out_ready = 1'b1;
`ifdef MUX_N_RR_CNT_EN
  logic [N*16-1:0] xfer_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mux_n_rr #(.N_CH(N), .DATA_W(W), .SEL_W(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_N_RR_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: state of the output register after the next rising edge.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_ch = 0;
  int           m_ptr = 0;

  initial begin
    forever begin
      int g;
      bit gv, ld;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      #3;
      if (!rst_n) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_in_ready", in_ready, 0);
        m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0;
      end else begin
        check("mdl_out_valid", out_valid, m_valid);
        check("mdl_out_data", out_data, m_data);
        check("mdl_out_ch", out_ch, m_ch);
        ld = !m_valid || out_ready;
        g = 0; gv = 0;
        if (!mode) begin
          g = int'(sel);
          gv = (g < N) && in_valid[g];
        end else begin
          for (int k = 0; k < N; k++) begin
            if (!gv && in_valid[(m_ptr + k) % N]) begin
              g = (m_ptr + k) % N;
              gv = 1;
            end
          end
        end
        exp_rdy = (ld && gv) ? (N'(1) << g) : '0;
        check("mdl_in_ready", in_ready, exp_rdy);
        if (ld) begin
          m_valid = gv;
          if (gv) begin
            m_data = in_data[g*W +: W];
            m_ch = g;
            if (mode) m_ptr = (g + 1) % N;
          end
        end
      end
    end
  end

  initial begin
    int rst_hold;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = {4'hA, 4'(i)};

    @(negedge clk); #1;
    check("t1_out_valid", out_valid, 0);
    check("t1_out_data", out_data, 0);
    check("t1_out_ch", out_ch, 0);
    check("t1_in_ready", in_ready, 0);

    @(negedge clk);
    rst_n = 1; mode = 0; sel = 5; in_valid = 8'hFF; out_ready = 1;
    #1 check("t2_in_ready", in_ready, 8'h20);
    @(negedge clk); #1;
    check("t2_out_data", out_data, 8'hA5);
    check("t2_out_ch", out_ch, 5);
    check("t2_out_valid", out_valid, 1);

    mode = 1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); #1;
      check("t3_rr_ch", out_ch, k % 8);
      check("t3_rr_valid", out_valid, 1);
    end

    in_valid = 8'h81;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("t4_rr_ch", out_ch, (k % 2 == 0) ? 7 : 0);
    end

    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("t5_stall_ch", out_ch, 0);
      check("t5_stall_data", out_data, 8'hA0);
      check("t5_stall_valid", out_valid, 1);
      check("t5_stall_rdy", in_ready, 0);
    end
    out_ready = 1;
    #1 check("t5_release_rdy", in_ready, 8'h80);
    @(negedge clk); #1;
    check("t5_next_ch", out_ch, 7);
    check("t5_next_data", out_data, 8'hA7);

    rst_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 0;
        rst_hold = 2;
      end
      in_data  = {$urandom, $urandom};
      in_valid = N'($urandom);
      if ($urandom_range(0, 3) == 0) in_valid = '0;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      sel = S'($urandom);
    end
    @(negedge clk);
    rst_n = 1;

`ifdef MUX_N_RR_CNT_EN
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    mode = 0; sel = 2; in_valid = 8'h04; out_ready = 1;
    repeat (70000) @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) check("t6_xfer_cnt", xfer_cnt[i*16 +: 16], (i == 2) ? 16'hFFFF : 16'h0);
`endif

    @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
